// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scanout block.
package vga_pkg;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    DRAINING = 2'd2
  } scanout_state_t;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb444_t;

  localparam int DEF_BUS_WIDTH = 12;
  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Counter width for an axis; a total of 1 still needs one bit to hold 0.
  function automatic int axis_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running horizontal/vertical raster counters and region decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic clock,
  input  logic reset,
  output logic active_o,
  output logic hsync_pulse_o,
  output logic vsync_pulse_o,
  output logic origin_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = axis_width(H_TOTAL);
  localparam int VW = axis_width(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] h_count_q, h_count_d;
  logic [VW-1:0] v_count_q, v_count_d;
  logic          h_wrap, v_wrap;

  assign h_wrap = (h_count_q == H_LAST);
  assign v_wrap = (v_count_q == V_LAST);

  // Next raster position: h always advances, v advances when h wraps.
  always_comb begin
    h_count_d = h_wrap ? '0 : h_count_q + 1'b1;
    v_count_d = v_count_q;
    if (h_wrap) begin
      v_count_d = v_wrap ? '0 : v_count_q + 1'b1;
    end
  end

  // Counter registers; they run from reset regardless of scanout state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_count_q <= '0;
      v_count_q <= '0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  assign active_o      = (h_count_q < H_ACT_END) && (v_count_q < V_ACT_END);
  assign hsync_pulse_o = (h_count_q >= H_SYNC_BEG) && (h_count_q < H_SYNC_END);
  assign vsync_pulse_o = (v_count_q >= V_SYNC_BEG) && (v_count_q < V_SYNC_END);
  assign origin_o      = (h_count_q == '0) && (v_count_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: frame-aligned start/stop FSM, FIFO pop, registered DAC outputs.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int BUS_WIDTH       = DEF_BUS_WIDTH,
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [BUS_WIDTH-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic [3:0]           red,
  output logic [3:0]           green,
  output logic [3:0]           blue,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start,
  output logic                 underflow,
  output logic                 running
);

  localparam logic SYNC_PULSE = ~SYNC_ACTIVE_LOW;
  localparam logic SYNC_IDLE  = SYNC_ACTIVE_LOW;

  logic active, hsync_pulse, vsync_pulse, origin;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .clock         (clock),
    .reset         (reset),
    .active_o      (active),
    .hsync_pulse_o (hsync_pulse),
    .vsync_pulse_o (vsync_pulse),
    .origin_o      (origin)
  );

  scanout_state_t state_q, state_d;
  rgb444_t        pixel_q, pixel_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           frame_start_q, frame_start_d;
  logic           underflow_q, underflow_d;
  logic           running_q, running_d;
  logic           scanning;
  logic           underflow_pixel;

  // Next-state and pixel decode. The decision taken at (0,0) applies to
  // pixel (0,0) itself, so a frame is always scanned from its first pixel
  // and a running frame is finished before stopping.
  always_comb begin
    state_d = state_q;
    if (origin) begin
      state_d = enable ? RUNNING : STOPPED;
    end else begin
      unique case (state_q)
        STOPPED:  state_d = STOPPED;
        RUNNING:  if (!enable) state_d = DRAINING;
        DRAINING: if (enable)  state_d = RUNNING;
        default:  state_d = STOPPED;
      endcase
    end

    scanning        = (state_d != STOPPED);
    fifo_read       = active & scanning & ~fifo_empty & ~reset;
    underflow_pixel = active & scanning & fifo_empty;

    pixel_d = '0;
    if (fifo_read) begin
      pixel_d = rgb444_t'(fifo_data[11:0]);
    end

    hsync_d       = hsync_pulse ? SYNC_PULSE : SYNC_IDLE;
    vsync_d       = vsync_pulse ? SYNC_PULSE : SYNC_IDLE;
    frame_start_d = origin;
    running_d     = scanning;

    // An underflow on pixel (0,0) belongs to the new frame, so set wins.
    underflow_d = underflow_q;
    if (origin)          underflow_d = 1'b0;
    if (underflow_pixel) underflow_d = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Single output stage; every DAC-side signal lags the counters by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_q       <= '0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      pixel_q       <= pixel_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      running_q     <= running_d;
    end
  end

  assign red         = pixel_q.red;
  assign green       = pixel_q.green;
  assign blue        = pixel_q.blue;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
  assign running     = running_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout on a tiny 8x6 raster.
module tb_vga_scanout;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] fifo_data = 12'h000;
  logic        fifo_empty = 1'b1;
  logic        fifo_read;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, frame_start, underflow, running;

  vga_scanout #(
    .BUS_WIDTH       (12),
    .H_ACTIVE        (HA),
    .H_FRONT         (HF),
    .H_SYNC          (HS),
    .H_BACK          (HB),
    .V_ACTIVE        (VA),
    .V_FRONT         (VF),
    .V_SYNC          (VS),
    .V_BACK          (VB),
    .SYNC_ACTIVE_LOW (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .fifo_read   (fifo_read),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start),
    .underflow   (underflow),
    .running     (running)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  // Reference model: the bench is the FIFO; a frame is scanned iff enable
  // was high at its first pixel, and stays scanned to its last pixel.
  logic [11:0] fifo_q[$];
  int          pos;
  bit          frame_on;
  bit          exp_uf;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (pos %0d, t=%0t)", tag, obs, exp, pos, $time);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 12'h000 : fifo_q[0];
  endtask

  task automatic fill_fifo(input int level);
    while (fifo_q.size() < level) fifo_q.push_back(12'($urandom));
    refresh_fifo();
  endtask

  task automatic check_reset_values();
    check_val("rst_fifo_read", fifo_read, 0);
    check_val("rst_rgb", {red, green, blue}, 0);
    check_val("rst_hsync", hsync, 1);
    check_val("rst_vsync", vsync, 1);
    check_val("rst_frame_start", frame_start, 0);
    check_val("rst_underflow", underflow, 0);
    check_val("rst_running", running, 0);
  endtask

  // One pixel clock: called at a falling edge with inputs already set.
  task automatic step(input bit fill);
    int          h, v, old_pos;
    bit          act, pop;
    logic [11:0] px;
    if (fill) fill_fifo(16);
    #1;
    h = pos % HT;
    v = pos / HT;
    old_pos = pos;
    if (pos == 0) begin
      frame_on = enable;
      exp_uf   = 1'b0;
    end
    act = (h < HA) && (v < VA);
    pop = act && frame_on && (fifo_q.size() > 0);
    if (act && frame_on && fifo_q.size() == 0) exp_uf = 1'b1;
    px = pop ? fifo_q[0] : 12'h000;
    check_val("fifo_read", fifo_read, pop);
    @(posedge clock);
    #1;
    if (pop) begin
      void'(fifo_q.pop_front());
      n_pop++;
      $display("pop %0d: data 0x%03h at h=%0d v=%0d", n_pop, px, h, v);
    end
    refresh_fifo();
    pos = (pos + 1) % FRAME;
    check_val("rgb", {red, green, blue}, px);
    check_val("hsync", hsync, !(h >= HA + HF && h < HA + HF + HS));
    check_val("vsync", vsync, !(v >= VA + VF && v < VA + VF + VS));
    check_val("frame_start", frame_start, old_pos == 0);
    check_val("underflow", underflow, exp_uf);
    check_val("running", running, frame_on);
    @(negedge clock);
  endtask

  task automatic run(input int n, input bit fill);
    for (int i = 0; i < n; i++) step(fill);
  endtask

  task automatic run_to(input int target, input bit fill);
    while (pos != target) step(fill);
  endtask

  task automatic model_reset();
    pos      = 0;
    frame_on = 1'b0;
    exp_uf   = 1'b0;
  endtask

  initial begin
    model_reset();
    refresh_fifo();
    repeat (2) @(posedge clock);
    #1;
    check_reset_values();
    @(negedge clock);
    reset = 1'b0;

    // Idle timing: two frames with enable low and an empty FIFO.
    run(2 * FRAME, 1'b0);

    // Normal scanout: 12 words, enable raised mid-frame.
    for (int i = 1; i <= 12; i++) fifo_q.push_back(12'(i));
    refresh_fifo();
    run(20, 1'b0);
    enable = 1'b1;
    run_to(0, 1'b0);
    run(FRAME, 1'b0);

    // Underflow: two words at frame start, then a full FIFO to clear it.
    fifo_q.push_back(12'hF00);
    fifo_q.push_back(12'h0F0);
    refresh_fifo();
    run(FRAME, 1'b0);
    run(FRAME, 1'b1);

    // Enable drop at line 1 pixel 2: drain this frame, idle the next.
    run_to(HT + 2, 1'b1);
    enable = 1'b0;
    run_to(0, 1'b1);
    run(FRAME, 1'b1);

    // Randomized enable toggles and FIFO fill levels.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) begin
        fifo_q.push_back(12'($urandom));
        refresh_fifo();
      end
      step(1'b0);
    end

    // Reset mid-frame during line 2, asserted between clock edges.
    enable = 1'b1;
    fill_fifo(16);
    run_to(2 * HT + 1, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_reset_values();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    run(FRAME + 12, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
